// File: rtl/nn_pkg.sv
// Shared constants and types for the RAM-based network layer and its front end.
package nn_pkg;

  localparam int NN_DATA_WIDTH  = 8;
  localparam int NN_INPUT_WIDTH = 49;

  typedef enum logic [2:0] {
    LD_LOAD    = 3'd0,
    LD_SKIP    = 3'd1,
    LD_FLUSH   = 3'd2,
    LD_REQ     = 3'd3,
    LD_RELEASE = 3'd4
  } loader_state_e;

endpackage

// File: rtl/nn_input_loader.sv
// Streams one frame of activations into the layer's input BRAM, then starts the
// layer over a four-phase req/ack handshake. Wrong-length frames are dropped.
module nn_input_loader
  import nn_pkg::*;
#(
  parameter int InputWidth = NN_INPUT_WIDTH,
  parameter int DataWidth  = NN_DATA_WIDTH,
  parameter int AddrWidth  = (InputWidth > 1) ? $clog2(InputWidth) : 1,
  parameter int CountWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DataWidth-1:0]  s_data_i,
  input  logic                  s_last_i,
  output logic                  actv_ram_we_o,
  output logic [AddrWidth-1:0]  actv_ram_addr_o,
  output logic [DataWidth-1:0]  actv_ram_din_o,
  output logic                  nn_req_o,
  input  logic                  nn_ack_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_len_o,
  output logic [CountWidth-1:0] frame_count_o
);

  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(InputWidth - 1);

  loader_state_e        state_q, state_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic                 accept, wr, err, done;

  assign accept = s_valid_i && s_ready_o;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr      = 1'b0;
    err     = 1'b0;
    done    = 1'b0;
    case (state_q)
      LD_LOAD: begin
        if (accept) begin
          wr = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (s_last_i) begin
              state_d = LD_FLUSH;
            end else begin
              err     = 1'b1;
              state_d = LD_SKIP;
            end
          end else if (s_last_i) begin
            // Short frame: partial writes stay in RAM, the layer is never started.
            err   = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + AddrWidth'(1);
          end
        end
      end
      LD_SKIP: begin
        if (accept && s_last_i) state_d = LD_LOAD;
      end
      LD_FLUSH: state_d = LD_REQ;
      LD_REQ: begin
        if (nn_ack_i) begin
          state_d = LD_RELEASE;
          done    = 1'b1;
        end
      end
      LD_RELEASE: begin
        if (!nn_ack_i) state_d = LD_LOAD;
      end
      default: state_d = LD_LOAD;
    endcase
  end

  // Outputs are registered from next-state values so each one lines up with the
  // state it describes, without combinational paths to the ports.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q         <= LD_LOAD;
      idx_q           <= '0;
      s_ready_o       <= 1'b0;
      busy_o          <= 1'b0;
      nn_req_o        <= 1'b0;
      actv_ram_we_o   <= 1'b0;
      actv_ram_addr_o <= '0;
      actv_ram_din_o  <= '0;
      frame_done_o    <= 1'b0;
      err_len_o       <= 1'b0;
      frame_count_o   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      s_ready_o     <= (state_d == LD_LOAD) || (state_d == LD_SKIP);
      busy_o        <= !((state_d == LD_LOAD) && (idx_d == '0));
      nn_req_o      <= (state_d == LD_REQ);
      actv_ram_we_o <= wr;
      if (wr) begin
        actv_ram_addr_o <= idx_q;
        actv_ram_din_o  <= s_data_i;
      end
      frame_done_o <= done;
      err_len_o    <= err;
      if (done) frame_count_o <= frame_count_o + CountWidth'(1);
    end
  end

endmodule

// File: tb/tb_nn_input_loader.sv
// Directed vector bench for nn_input_loader with a 4-word frame.
module tb_nn_input_loader;

  localparam int IW = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          req;
  logic          ack = 1'b0;
  logic          busy, done, err;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nn_input_loader #(
    .InputWidth(IW), .DataWidth(DW), .AddrWidth(AW), .CountWidth(CW)
  ) dut (
    .clk_i(clk), .reset_i(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .actv_ram_we_o(we), .actv_ram_addr_o(addr), .actv_ram_din_o(din),
    .nn_req_o(req), .nn_ack_i(ack),
    .busy_o(busy), .frame_done_o(done), .err_len_o(err), .frame_count_o(cnt)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          a;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rdy;
    logic          req;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic l, logic a,
                              logic e_we, logic [AW-1:0] e_addr, logic [DW-1:0] e_din,
                              logic e_rdy, logic e_req, logic e_busy, logic e_done,
                              logic e_err, logic [CW-1:0] e_cnt);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.a = a;
    r.we = e_we; r.addr = e_addr; r.din = e_din; r.rdy = e_rdy; r.req = e_req;
    r.busy = e_busy; r.done = e_done; r.err = e_err; r.cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input logic ok, input string name, input string info);
    n_checks++;
    if (ok !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  function automatic string outs();
    return $sformatf("we=%0b addr=%0d din=%02h rdy=%0b req=%0b busy=%0b done=%0b err=%0b cnt=%0d",
                     we, addr, din, s_ready, req, busy, done, err, cnt);
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic run_q(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      vec_t e;
      logic ok;
      e = vq[i];
      @(negedge clk);
      s_valid = e.v; s_data = e.d; s_last = e.l; ack = e.a;
      @(posedge clk);
      #1;
      ok = (we === e.we) && (!e.we || (addr === e.addr && din === e.din)) &&
           (s_ready === e.rdy) && (req === e.req) && (busy === e.busy) &&
           (done === e.done) && (err === e.err) && (cnt === e.cnt);
      chk(ok, $sformatf("%s[%0d]", name, i),
          $sformatf("got %s ; want we=%0b addr=%0d din=%02h rdy=%0b req=%0b busy=%0b done=%0b err=%0b cnt=%0d",
                    outs(), e.we, e.addr, e.din, e.rdy, e.req, e.busy, e.done, e.err, e.cnt));
    end
    vq.delete();
  endtask

  logic [DW-1:0] gd [4];
  int sent, nwr;

  task automatic gap_step();
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      chk(nwr < 4 && addr === AW'(nwr) && din === gd[nwr & 3], "gap_write",
          $sformatf("write #%0d got addr=%0d din=%02h", nwr, addr, din));
      nwr++;
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk(s_ready === 1'b0 && req === 1'b0 && busy === 1'b0 && we === 1'b0 && done === 1'b0 &&
        err === 1'b0 && cnt === '0, "reset_vals", $sformatf("got %s ; want all 0", outs()));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(s_ready === 1'b1 && busy === 1'b0, "after_reset", $sformatf("got %s ; want rdy=1 busy=0", outs()));

    // Nominal frame, valid held high into REQ, ack held 3 cycles
    vq.push_back(mk(1, 8'h11, 0, 0, 1, 0, 8'h11, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 8'h22, 0, 0, 1, 1, 8'h22, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 8'h33, 0, 0, 1, 2, 8'h33, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 8'h44, 1, 0, 1, 3, 8'h44, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 8'h99, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(1, 8'h99, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
    run_q("nominal");

    // Short frame: error pulse, no request
    vq.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'hA1, 1, 0, 1, 0, 0, 1));
    vq.push_back(mk(1, 8'hA2, 1, 0, 1, 1, 8'hA2, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1));
    run_q("short");

    // Correct frame with random valid gaps; must restart at addr 0
    gd[0] = 8'h55; gd[1] = 8'h66; gd[2] = 8'h77; gd[3] = 8'h88;
    sent = 0; nwr = 0;
    for (int c = 0; c < 40 && sent < 4; c++) begin
      @(negedge clk);
      if ($urandom_range(1, 0) == 1) begin
        s_valid = 1'b1; s_data = gd[sent]; s_last = (sent == 3); sent++;
      end else begin
        s_valid = 1'b0; s_data = 8'hEE; s_last = 1'b1;
      end
      gap_step();
    end
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
    gap_step();
    gap_step();
    chk(req === 1'b1 && s_ready === 1'b0, "gap_req", $sformatf("got %s ; want req=1 rdy=0", outs()));
    chk(nwr == 4, "gap_count", $sformatf("got %0d writes ; want 4", nwr));
    gap_step();
    chk(req === 1'b1 && s_ready === 1'b0 && we === 1'b0, "gap_hold", $sformatf("got %s ; want req=1 rdy=0 we=0", outs()));
    @(negedge clk);
    ack = 1'b1;
    gap_step();
    chk(req === 1'b0 && done === 1'b1 && cnt === 16'd2 && s_ready === 1'b0, "gap_ack",
        $sformatf("got %s ; want req=0 done=1 cnt=2 rdy=0", outs()));
    @(negedge clk);
    ack = 1'b0; s_valid = 1'b0;
    gap_step();
    chk(s_ready === 1'b1 && busy === 1'b0 && nwr == 4, "gap_release",
        $sformatf("got %s writes=%0d ; want rdy=1 busy=0 writes=4", outs(), nwr));

    // Long frame: error on 4th beat, remaining beats skipped
    vq.push_back(mk(1, 8'hB1, 0, 0, 1, 0, 8'hB1, 1, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 8'hB2, 0, 0, 1, 1, 8'hB2, 1, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 8'hB3, 0, 0, 1, 2, 8'hB3, 1, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 8'hB4, 0, 0, 1, 3, 8'hB4, 1, 0, 1, 0, 1, 2));
    vq.push_back(mk(1, 8'hB5, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 8'hB6, 1, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 2));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 2));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 2));
    run_q("long");

    // Ack already high before REQ: completes next cycle, RELEASE waits for ack low
    vq.push_back(mk(1, 8'hD1, 0, 1, 1, 0, 8'hD1, 1, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 8'hD2, 0, 1, 1, 1, 8'hD2, 1, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 8'hD3, 0, 1, 1, 2, 8'hD3, 1, 0, 1, 0, 0, 2));
    vq.push_back(mk(1, 8'hD4, 1, 1, 1, 3, 8'hD4, 0, 0, 1, 0, 0, 2));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0, 0, 2));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3));
    vq.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 3));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 3));
    run_q("stuck_ack");

    // Reset asserted while in REQ
    vq.push_back(mk(1, 8'hE1, 0, 0, 1, 0, 8'hE1, 1, 0, 1, 0, 0, 3));
    vq.push_back(mk(1, 8'hE2, 0, 0, 1, 1, 8'hE2, 1, 0, 1, 0, 0, 3));
    vq.push_back(mk(1, 8'hE3, 0, 0, 1, 2, 8'hE3, 1, 0, 1, 0, 0, 3));
    vq.push_back(mk(1, 8'hE4, 1, 0, 1, 3, 8'hE4, 0, 0, 1, 0, 0, 3));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0, 3));
    run_q("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk(req === 1'b0 && busy === 1'b0 && cnt === '0 && s_ready === 1'b0, "async_reset",
        $sformatf("got %s ; want req=0 busy=0 cnt=0 rdy=0", outs()));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(s_ready === 1'b1 && req === 1'b0, "post_reset", $sformatf("got %s ; want rdy=1 req=0", outs()));
    vq.push_back(mk(1, 8'hC1, 0, 0, 1, 0, 8'hC1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 8'hC2, 0, 0, 1, 1, 8'hC2, 1, 0, 1, 0, 0, 0));
    run_q("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/nn_input_loader.md
# nn_input_loader

Front-end stage for the RAM-based network layer. It accepts a stream of input activations over a valid/ready handshake and writes them sequentially into the layer's input-activation RAM port (port b of the input BRAM). It then runs a four-phase req/ack handshake with the layer to start inference on the complete frame. Frames of the wrong length are flagged and dropped without starting the layer.

## Interface
Parameters:
- InputWidth, 49, activations per frame (RAM words written per frame)
- DataWidth, 8, activation width (fixed-point, same format as the layer)
- AddrWidth, $clog2(InputWidth), input-activation RAM address width
- CountWidth, 16, width of completed-frame counter

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- reset_i  in  1  asynchronous, active-low reset
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  loader can accept a beat
- s_data_i  in  DataWidth  activation value
- s_last_i  in  1  final beat of frame
- actv_ram_we_o  out  1  write strobe to input-activation RAM
- actv_ram_addr_o  out  AddrWidth  write address
- actv_ram_din_o  out  DataWidth  write data
- nn_req_o  out  1  start request to layer (level)
- nn_ack_i  in  1  layer completion (level)
- busy_o  out  1  high in any state other than LOAD with index 0
- frame_done_o  out  1  one-cycle pulse per completed inference
- err_len_o  out  1  one-cycle pulse on length error
- frame_count_o  out  CountWidth  completed frames, wraps at 2^CountWidth

## Operation
- States: LOAD, SKIP, FLUSH, REQ, RELEASE.
- Beat accepted when s_valid_i && s_ready_o. s_ready_o = 1 in LOAD and SKIP only.
- Write index idx is held in a counter, 0..InputWidth-1.
- **LOAD**, on accept:
  - Register a write with addr = idx and data = s_data_i.
  - idx == InputWidth-1 with s_last_i=1: go to FLUSH, idx ← 0.
  - s_last_i=1 with idx < InputWidth-1 (short frame): pulse err_len_o, idx ← 0, stay in LOAD. Writes already made are left in RAM; no request is issued.
  - idx == InputWidth-1 with s_last_i=0 (long frame): pulse err_len_o, idx ← 0, go to SKIP.
  - Otherwise idx ← idx+1.
- **SKIP**: accept and discard beats with no writes. Accepting a beat with s_last_i=1 returns to LOAD.
- **FLUSH**: one cycle so the final write lands in the BRAM. Go to REQ.
- **REQ**: nn_req_o=1. When nn_ack_i is sampled high: nn_req_o ← 0, frame_done_o pulse, frame_count_o+1, go to RELEASE.
- **RELEASE**: wait for nn_ack_i=0, then go to LOAD.
- nn_ack_i is ignored outside REQ and RELEASE.
- Data is passed through unmodified; no arithmetic on activations.

## Timing
- All outputs are registered.
- Reset values: s_ready_o=0 while reset is asserted, then 1 on the first cycle after release (state LOAD). All other outputs are 0, idx=0, frame_count_o=0.
- Beat accepted at cycle t: actv_ram_we_o/addr/din are valid at t+1 for exactly one cycle.
- Last beat at t: write at t+1 (FLUSH), nn_req_o rises at t+2.
- nn_ack_i high at cycle a: nn_req_o low, frame_done_o high and frame_count_o updated at a+1.
- Minimum frame-to-frame gap: ack must fall. s_ready_o returns the cycle after nn_ack_i is sampled low.
- Throughput in LOAD/SKIP: one beat per cycle.
- Asynchronous reset mid-frame or mid-handshake: immediate return to reset values. A partially written RAM is not cleared.
- InputWidth=1: every beat must carry s_last_i=1, else SKIP.

## Structure
- A shared package nn_pkg holds the state enum typedef (loader_state_e) and the default DataWidth/InputWidth constants used by the layer.
- No sub-modules. Single always_ff for state, idx, write registers and counters. Single always_comb for next state.

## Test plan
- Nominal: InputWidth=4, beats 0x11,0x22,0x33,0x44 (last on 4th) → writes addr 0..3 with those values at t+1..t+4. nn_req_o rises 2 cycles after last. Ack held 3 cycles → frame_done_o one pulse, frame_count_o=1, s_ready_o only after ack drops.
- Backpressure and gaps: random s_valid_i gaps → same 4 writes in order, no duplicates. s_ready_o=0 throughout REQ/RELEASE even with s_valid_i=1.
- Short frame: 2 beats, last on 2nd → err_len_o pulse, no nn_req_o. Next correct frame writes from addr 0.
- Long frame: 6 beats, last on 6th → err_len_o at 4th beat, beats 5–6 produce no writes, back to LOAD, no request.
- Ack stuck high entering REQ: ack already 1 → request completes next cycle, then RELEASE holds until ack=0.
- Reset asserted during REQ → nn_req_o, busy_o and frame_count_o go to 0 asynchronously. After release, s_ready_o=1 and a new frame starts at addr 0.
